tick_meter: RTL and testbench
=============================

# tick_meter

Measures an incoming tick stream, such as `gen_tick` output, over a fixed window of source-clock cycles. It reports the rising-edge count, the high-cycle count and a pass/fail range flag. It is the receive-side checker for the tick generators. It lets hardware (and later the lab board) self-verify tick frequency and load instead of relying on a bench loop. It runs continuously, back-to-back windows, while enabled.

## Interface
- `SRC_FREQ`, 100: source clock frequency in Hz. Documentation/derivation only; not used in arithmetic.
- `WINDOW`, 1000: measurement window length in `src_clk` cycles. Must be ≥ 2.
- `CNT_W`, 16: width of the result counters.
- `EXP_MIN`, 0: minimum acceptable edge count per window.
- `EXP_MAX`, 65535: maximum acceptable edge count per window.
- `src_clk`  in  1  source clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run measurement windows while high.
- `tick_in`  in  1  tick under test, synchronous to `src_clk`.
- `edge_count`  out  CNT_W  rising edges in the last completed window.
- `high_count`  out  CNT_W  cycles with `tick_in`=1 in the last completed window.
- `overflow`  out  1  either counter saturated in the last completed window.
- `in_range`  out  1  `EXP_MIN` ≤ `edge_count` ≤ `EXP_MAX` and not `overflow`.
- `valid`  out  1  one-cycle pulse: the result outputs were just updated.
- `busy`  out  1  a window is in progress.

## Operation
- FSM has two states: IDLE and MEASURE.
- **IDLE → MEASURE:** at an edge where `enable`=1. That edge is window sample 0.
- **MEASURE → IDLE:** at any edge where `enable`=0. The window is aborted, no `valid` is produced, and the result outputs keep their previous values.
- **Sampling:** in MEASURE, every edge samples `tick_in`, so the window covers samples 0..WINDOW-1.
- **Edge rule:** a rising edge is counted when `tick_in`=1 and either the previous sample was 0 or this is sample 0. The previous-sample register is treated as 0 at window start.
- **High count:** `high_count` increments on every sample with `tick_in`=1.
- **Saturation:** both working counters saturate at 2^CNT_W−1. Any saturation sets the window's overflow flag.
- **Window close:** at the sample WINDOW-1 edge, the final counts (including that sample) load into `edge_count`, `high_count`, `overflow` and `in_range`. The working counters clear.
- **Continuous mode:** if `enable` is still 1 at the close edge, the next edge is sample 0 of a new window, with no gap cycle.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE and the working counters are 0.
- **Reset mid-window:** the next cycle shows all outputs at 0 and no `valid`.
- `busy`=1 exactly while the state is MEASURE. It is registered, so it is visible the cycle after the entering edge.
- `valid` is high for exactly one cycle, the cycle following the sample WINDOW-1 edge. Results are stable from that cycle until the next `valid`.
- The period between `valid` pulses is exactly WINDOW cycles while `enable` stays high.
- **`enable` falling on the close edge:** the result loads, `valid` pulses, and the state goes to IDLE.
- **`in_range`** is computed from the saturated counts and registered together with them, so there is no extra latency.

## Structure
- `tick_meter_pkg` holds:
  - the state enum (IDLE, MEASURE);
  - the default `CNT_W`;
  - the window-counter width function, clog2(WINDOW).
- One sub-module, `sat_counter` (parameter W; ports clear, inc, value, sat), is instantiated twice, once for edges and once for high cycles.
- The window counter, edge-detect register, FSM and result registers live in the top-level module.

## Test plan
- **Tick generator drive:** `gen_tick` with SRC_FREQ=100, TICK_FREQ=2 drives `tick_in`; WINDOW=1000, EXP_MIN=EXP_MAX=20, `enable`=1 → first `valid` 1000 cycles after start with `edge_count`=20, `high_count`=500, `in_range`=1, `overflow`=0.
- **Constant high and alternating input:**
  - `tick_in` held at 1 → `edge_count`=1, `high_count`=1000.
  - `tick_in` toggling every cycle, starting at 1 on sample 0 → `edge_count`=500, `high_count`=500.
- **Abort and restart:** `enable` dropped at sample 400 → no `valid`, `busy`=0 the next cycle, previous results unchanged. Re-enable → `valid` after exactly 1000 further cycles.
- **Saturation:** CNT_W=8, `tick_in` held at 1 → `high_count`=255, `overflow`=1, `in_range`=0.
- **Reset mid-window:** `reset` asserted at sample 600 → all outputs 0 the next cycle and no `valid`. After release with `enable`=1, `valid` pulses every 1000 cycles with identical counts for a stationary input.

Source files
------------

// File: rtl/tick_meter_pkg.sv
// Shared types and sizing helpers for the tick_meter receive-side checker.
package tick_meter_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam int DEF_CNT_W = 16;

  // Width of the in-window sample index; holds 0..window-1.
  function automatic int win_cnt_w(input int window);
    return (window > 2) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         sat
);

  assign sat = &value;

  always_ff @(posedge clk) begin
    if (reset)              value <= '0;
    else if (clear)         value <= '0;
    else if (inc && !sat)   value <= value + W'(1);
  end

endmodule

// File: rtl/tick_meter.sv
// Counts rising edges and high cycles of tick_in over back-to-back windows of
// WINDOW src_clk cycles and reports the totals plus a range verdict.
module tick_meter
  import tick_meter_pkg::*;
#(
  parameter int SRC_FREQ = 100,
  parameter int WINDOW   = 1000,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXP_MIN  = 0,
  parameter int EXP_MAX  = 65535
) (
  input  logic             src_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_in,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] high_count,
  output logic             overflow,
  output logic             in_range,
  output logic             valid,
  output logic             busy
);

  localparam int               WCW     = win_cnt_w(WINDOW);
  localparam logic [WCW-1:0]   LAST    = WCW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // SRC_FREQ only documents the clock the window is sized against.
  if (SRC_FREQ <= 0 || WINDOW < 2) begin : g_bad_params
  end

  meter_state_t     state;
  logic [WCW-1:0]   win_cnt;
  logic             prev_tick;
  logic             last, smp, clr, edge_inc, high_inc;
  logic [CNT_W-1:0] edge_val, high_val, edge_fin, high_fin;
  logic             edge_sat, high_sat, ovf_fin, lo_ok, hi_ok, inr_fin;

  // The close edge samples even if enable has just dropped; any other edge
  // with enable low aborts the window.
  assign last     = (state == MEASURE) && (win_cnt == LAST);
  assign smp      = enable || last;
  assign clr      = !smp || last;
  assign edge_inc = smp && tick_in && !prev_tick;
  assign high_inc = smp && tick_in;

  sat_counter #(.W(CNT_W)) u_edge_cnt (
    .clk(src_clk), .reset(reset), .clear(clr), .inc(edge_inc),
    .value(edge_val), .sat(edge_sat)
  );

  sat_counter #(.W(CNT_W)) u_high_cnt (
    .clk(src_clk), .reset(reset), .clear(clr), .inc(high_inc),
    .value(high_val), .sat(high_sat)
  );

  // Final totals include the sample taken on the close edge itself.
  assign edge_fin = (edge_inc && !edge_sat) ? edge_val + CNT_W'(1) : edge_val;
  assign high_fin = (high_inc && !high_sat) ? high_val + CNT_W'(1) : high_val;
  assign ovf_fin  = (edge_fin == CNT_MAX) || (high_fin == CNT_MAX);

  if (EXP_MIN <= 0) begin : g_lo
    assign lo_ok = 1'b1;
  end else begin : g_lo
    assign lo_ok = 64'(edge_fin) >= 64'(EXP_MIN);
  end

  if (longint'(EXP_MAX) >= ((longint'(1) << CNT_W) - 1)) begin : g_hi
    assign hi_ok = 1'b1;
  end else begin : g_hi
    assign hi_ok = 64'(edge_fin) <= 64'(EXP_MAX);
  end

  assign inr_fin = lo_ok && hi_ok && !ovf_fin;
  assign busy    = (state == MEASURE);

  always_ff @(posedge src_clk) begin
    if (reset) begin
      state      <= IDLE;
      win_cnt    <= '0;
      prev_tick  <= 1'b0;
      edge_count <= '0;
      high_count <= '0;
      overflow   <= 1'b0;
      in_range   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      state     <= enable ? MEASURE : IDLE;
      win_cnt   <= clr ? '0 : win_cnt + WCW'(1);
      prev_tick <= smp && !last && tick_in;
      valid     <= last;
      if (last) begin
        edge_count <= edge_fin;
        high_count <= high_fin;
        overflow   <= ovf_fin;
        in_range   <= inr_fin;
      end
    end
  end

endmodule

// File: tb/tb_tick_meter.sv
// Directed bench for tick_meter: a vector table of whole windows plus
// hand-written abort, close-edge disable and mid-window reset sequences.
module tb_tick_meter;

  localparam int WINDOW = 1000;

  logic        src_clk = 1'b0;
  logic        reset, enable, tick_in;
  logic [15:0] a_edge, a_high;
  logic        a_ovf, a_inr, a_valid, a_busy;
  logic [7:0]  b_edge, b_high;
  logic        b_ovf, b_inr, b_valid, b_busy;

  always #5 src_clk = ~src_clk;

  tick_meter #(.SRC_FREQ(100), .WINDOW(WINDOW), .CNT_W(16), .EXP_MIN(20), .EXP_MAX(20)) dut_a (
    .src_clk(src_clk), .reset(reset), .enable(enable), .tick_in(tick_in),
    .edge_count(a_edge), .high_count(a_high), .overflow(a_ovf), .in_range(a_inr),
    .valid(a_valid), .busy(a_busy)
  );

  tick_meter #(.SRC_FREQ(100), .WINDOW(WINDOW), .CNT_W(8), .EXP_MIN(0), .EXP_MAX(65535)) dut_b (
    .src_clk(src_clk), .reset(reset), .enable(enable), .tick_in(tick_in),
    .edge_count(b_edge), .high_count(b_high), .overflow(b_ovf), .in_range(b_inr),
    .valid(b_valid), .busy(b_busy)
  );

  typedef struct {
    int pat;
    int a_e, a_h, a_o, a_r;
    int b_e, b_h, b_o, b_r;
  } vec_t;

  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0: gen_tick 100 Hz -> 2 Hz (25 high / 25 low), 1: const high,
  // 2: toggle starting high, 3: const low, 4: 1-cycle pulse every 50,
  // 5: single high on the final sample only.
  function automatic logic tick_of(input int p, input int s);
    case (p)
      0:       return (s % 50) < 25;
      1:       return 1'b1;
      2:       return (s % 2) == 0;
      3:       return 1'b0;
      4:       return (s % 50) == 0;
      default: return s == WINDOW - 1;
    endcase
  endfunction

  task automatic step();
    @(posedge src_clk);
    #1;
  endtask

  task automatic run_samples(input int p, input int first, input int n, output int mid_valid);
    mid_valid = 0;
    for (int s = first; s < first + n; s++) begin
      tick_in = tick_of(p, s);
      step();
      if (a_valid || b_valid) mid_valid++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " a_edge"},  a_edge,  0);
    check({tag, " a_high"},  a_high,  0);
    check({tag, " a_ovf"},   a_ovf,   0);
    check({tag, " a_inr"},   a_inr,   0);
    check({tag, " a_valid"}, a_valid, 0);
    check({tag, " a_busy"},  a_busy,  0);
    check({tag, " b_high"},  b_high,  0);
    check({tag, " b_inr"},   b_inr,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv, n, got;

    vecs[0] = '{0,  20,  500, 0, 1,   20, 255, 1, 0};
    vecs[1] = '{1,   1, 1000, 0, 0,    1, 255, 1, 0};
    vecs[2] = '{2, 500,  500, 0, 0,  255, 255, 1, 0};
    vecs[3] = '{3,   0,    0, 0, 0,    0,   0, 0, 1};
    vecs[4] = '{4,  20,   20, 0, 1,   20,  20, 0, 1};
    vecs[5] = '{5,   1,    1, 0, 0,    1,   1, 0, 1};

    reset = 1'b1; enable = 1'b0; tick_in = 1'b0;
    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;
    step();
    check("idle busy", a_busy, 0);

    // Back-to-back windows: each close must land exactly WINDOW edges later.
    enable = 1'b1;
    foreach (vecs[i]) begin
      run_samples(vecs[i].pat, 0, WINDOW - 1, mv);
      check($sformatf("p%0d mid valid", vecs[i].pat), mv, 0);
      tick_in = tick_of(vecs[i].pat, WINDOW - 1);
      step();
      check($sformatf("p%0d a_valid", vecs[i].pat), a_valid, 1);
      check($sformatf("p%0d a_edge",  vecs[i].pat), a_edge,  vecs[i].a_e);
      check($sformatf("p%0d a_high",  vecs[i].pat), a_high,  vecs[i].a_h);
      check($sformatf("p%0d a_ovf",   vecs[i].pat), a_ovf,   vecs[i].a_o);
      check($sformatf("p%0d a_inr",   vecs[i].pat), a_inr,   vecs[i].a_r);
      check($sformatf("p%0d b_valid", vecs[i].pat), b_valid, 1);
      check($sformatf("p%0d b_edge",  vecs[i].pat), b_edge,  vecs[i].b_e);
      check($sformatf("p%0d b_high",  vecs[i].pat), b_high,  vecs[i].b_h);
      check($sformatf("p%0d b_ovf",   vecs[i].pat), b_ovf,   vecs[i].b_o);
      check($sformatf("p%0d b_inr",   vecs[i].pat), b_inr,   vecs[i].b_r);
    end
    check("continuous busy", a_busy, 1);

    // Abort at sample 400: results from the last window (pattern 5) persist.
    run_samples(0, 0, 400, mv);
    check("abort mid valid", mv, 0);
    enable = 1'b0;
    step();
    check("abort busy",  a_busy,  0);
    check("abort valid", a_valid, 0);
    check("abort edge",  a_edge,  1);
    check("abort high",  a_high,  1);
    n = 0;
    repeat (5) begin
      step();
      if (a_valid) n++;
    end
    check("abort idle valids", n, 0);

    enable = 1'b1;
    n = 0; got = 0;
    for (int k = 0; k < 1100 && got == 0; k++) begin
      tick_in = tick_of(0, k);
      step();
      n++;
      if (a_valid) got = 1;
    end
    check("restart valid seen", got, 1);
    check("restart latency",    n,   WINDOW);
    check("restart edge",       a_edge, 20);
    check("restart high",       a_high, 500);
    check("restart inr",        a_inr,  1);

    // enable low on the close edge still completes the window.
    run_samples(4, 0, WINDOW - 1, mv);
    check("enfall mid valid", mv, 0);
    enable = 1'b0;
    tick_in = tick_of(4, WINDOW - 1);
    step();
    check("enfall valid", a_valid, 1);
    check("enfall busy",  a_busy,  0);
    check("enfall edge",  a_edge,  20);
    check("enfall high",  a_high,  20);
    check("enfall inr",   a_inr,   1);
    step();
    check("enfall valid pulse", a_valid, 0);

    // Reset at sample 600, then stationary input gives identical windows.
    enable = 1'b1;
    run_samples(1, 0, 600, mv);
    reset = 1'b1;
    step();
    check_zero("midreset");
    reset = 1'b0;
    for (int w = 0; w < 2; w++) begin
      run_samples(1, 0, WINDOW - 1, mv);
      check($sformatf("post-reset w%0d mid valid", w), mv, 0);
      tick_in = 1'b1;
      step();
      check($sformatf("post-reset w%0d valid",  w), a_valid, 1);
      check($sformatf("post-reset w%0d edge",   w), a_edge,  1);
      check($sformatf("post-reset w%0d high",   w), a_high,  1000);
      check($sformatf("post-reset w%0d b_high", w), b_high,  255);
      check($sformatf("post-reset w%0d b_ovf",  w), b_ovf,   1);
      check($sformatf("post-reset w%0d b_inr",  w), b_inr,   0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
